// File: rtl/accel_mailbox_pkg.sv
// Shared types and register map for the accelerator mailbox.
// The ACCEL_TIMEOUT_EN watchdog option is resolved in accel_mailbox.sv.
package accel_mailbox_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_CMPL   = 2'd3
    } state_t;

    localparam int REG_CMD  = 0;
    localparam int REG_STAT = 0;
    localparam int REG_RES  = 1;
    localparam int REG_CYC  = 2;
    localparam int REG_CNT  = 3;
    localparam int REG_OP   = 4;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_ERR   = 2;
    localparam int STAT_OVR   = 3;
    localparam int STAT_TMO   = 4;
    localparam int STAT_STATE = 5;

    localparam logic [3:0] OP_NOP = 4'h0;

    function automatic logic [31:0] pack_status(
        input logic [7:0] seq,
        input state_t     st,
        input logic       tmo,
        input logic       ovr,
        input logic       err,
        input logic       done
    );
        logic [31:0] w_word;
        w_word                            = 32'h0000_0000;
        w_word[31:24]                     = seq;
        w_word[STAT_STATE+1 -: 2]         = st;
        w_word[STAT_TMO]                  = tmo;
        w_word[STAT_OVR]                  = ovr;
        w_word[STAT_ERR]                  = err;
        w_word[STAT_DONE]                 = done;
        w_word[STAT_BUSY]                 = (st != ST_IDLE);
        return w_word;
    endfunction

endpackage

// File: rtl/accel_mailbox_job_timer.sv
// Saturating job cycle counter with a watchdog threshold compare.
module accel_job_timer #(
    parameter int CYC_W       = 32,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [CYC_W-1:0] o_count,
    output logic             o_expired
);

    logic [CYC_W-1:0] r_count;

    // Count enabled cycles, holding at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != {CYC_W{1'b1}})) begin
            r_count <= r_count + CYC_W'(1);
        end
    end

    assign o_count   = r_count;
    assign o_expired = (r_count >= CYC_W'(TIMEOUT_CYC));

endmodule

// File: rtl/accel_mailbox.sv
// Accelerator-side mailbox: decodes CPU command regs, runs one engine job, reports status.
// Define ACCEL_TIMEOUT_EN to enable the RUN-state watchdog.
module accel_mailbox
    import accel_mailbox_pkg::*;
#(
    parameter int NUM_REGS    = 8,
    parameter int DATA_W      = 32,
    parameter int CYC_W       = 32,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] register_accelerator_out [NUM_REGS],
    output logic [DATA_W-1:0] register_accelerator_in  [NUM_REGS],
    output logic              job_valid,
    input  logic              job_ready,
    output logic [3:0]        job_op,
    output logic [DATA_W-1:0] job_arg [NUM_REGS-1],
    input  logic              job_done,
    input  logic [DATA_W-1:0] job_result,
    input  logic              job_err
);

    state_t            r_state;
    logic [7:0]        r_last_seq;
    logic [7:0]        r_acc_seq;
    logic [3:0]        r_op;
    logic [DATA_W-1:0] r_args [NUM_REGS-1];
    logic              r_job_valid;
    logic              r_done;
    logic              r_err;
    logic              r_ovr;
    logic              r_tmo;
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] r_jobs;

    logic [7:0]        w_seq;
    logic [3:0]        w_cmd_op;
    logic              w_seq_new;
    logic              w_accept;
    logic              w_finish_ok;
    logic              w_timeout;
    logic              w_tmo_en;
    logic              w_expired;
    logic [CYC_W-1:0]  w_count;

    assign w_seq     = register_accelerator_out[REG_CMD][DATA_W-1 -: 8];
    assign w_cmd_op  = register_accelerator_out[REG_CMD][3:0];
    assign w_seq_new = (w_seq != r_last_seq);
    assign w_accept  = (r_state == ST_IDLE) && w_seq_new && (w_cmd_op != OP_NOP);

`ifdef ACCEL_TIMEOUT_EN
    assign w_tmo_en = 1'b1;
`else
    assign w_tmo_en = 1'b0;
`endif

    // A done arriving together with the acceptance still counts; done elsewhere is dropped
    assign w_finish_ok = job_done && (((r_state == ST_LAUNCH) && job_ready) || (r_state == ST_RUN));
    assign w_timeout   = w_tmo_en && (r_state == ST_RUN) && w_expired && !job_done;

    accel_job_timer #(
        .CYC_W       (CYC_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_accept),
        .i_enable  ((r_state == ST_LAUNCH) || (r_state == ST_RUN)),
        .o_count   (w_count),
        .o_expired (w_expired)
    );

    // Command sequencing, job handshake and status bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_last_seq  <= 8'h00;
            r_acc_seq   <= 8'h00;
            r_op        <= 4'h0;
            r_job_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_ovr       <= 1'b0;
            r_tmo       <= 1'b0;
            r_result    <= '0;
            r_jobs      <= '0;
            for (int i = 0; i < NUM_REGS-1; i++) r_args[i] <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_seq_new) begin
                        r_last_seq <= w_seq;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_ovr      <= 1'b0;
                        r_tmo      <= 1'b0;
                        if (w_accept) begin
                            r_acc_seq   <= w_seq;
                            r_op        <= w_cmd_op;
                            r_job_valid <= 1'b1;
                            r_state     <= ST_LAUNCH;
                            for (int i = 0; i < NUM_REGS-1; i++)
                                r_args[i] <= register_accelerator_out[i+1];
                        end
                    end
                end
                ST_LAUNCH: begin
                    if (job_ready) begin
                        r_job_valid <= 1'b0;
                        r_state     <= job_done ? ST_CMPL : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (job_done || w_timeout) r_state <= ST_CMPL;
                end
                ST_CMPL: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase

            if (w_finish_ok || w_timeout) begin
                r_result <= w_finish_ok ? job_result : '0;
                r_err    <= w_finish_ok ? job_err : 1'b1;
                r_tmo    <= w_timeout;
                r_done   <= 1'b1;
                r_jobs   <= r_jobs + DATA_W'(1);
            end

            if ((r_state != ST_IDLE) && w_seq_new) r_ovr <= 1'b1;
        end
    end

    assign job_valid = r_job_valid;
    assign job_op    = r_op;
    assign job_arg   = r_args;

    // Status words presented to the CPU; unused indices read as zero
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) register_accelerator_in[i] = '0;
        register_accelerator_in[REG_STAT] = DATA_W'(pack_status(r_acc_seq, r_state, r_tmo,
                                                                r_ovr, r_err, r_done));
        register_accelerator_in[REG_RES]  = r_result;
        register_accelerator_in[REG_CYC]  = DATA_W'(w_count);
        register_accelerator_in[REG_CNT]  = r_jobs;
        register_accelerator_in[REG_OP]   = {{(DATA_W-4){1'b0}}, r_op};
    end

endmodule
